// File: rtl/fde_pkg.sv
// Shared definitions for the lab CPU front end: opcodes, widths and
// instruction field positions.
package fde_pkg;

    localparam int DW = 8;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_SHL  = 4'h5,
        OP_SHR  = 4'h6,
        OP_ADDI = 4'h7,
        OP_LD   = 4'h8,
        OP_ST   = 4'h9,
        OP_CMP  = 4'hA,
        OP_LBL  = 4'hB,
        OP_JMP  = 4'hC,
        OP_BZ   = 4'hD,
        OP_RST  = 4'hE,
        OP_SYS  = 4'hF
    } opcode_e;

    localparam int OP_MSB    = 7;
    localparam int OP_LSB    = 4;
    localparam int RD_MSB    = 3;
    localparam int RD_LSB    = 2;
    localparam int RS2_MSB   = 1;
    localparam int RS2_LSB   = 0;
    localparam int LBL_MSB   = 3;
    localparam int LBL_LSB   = 0;

    localparam logic [7:0] HALT_WORD = 8'hFF;

    function automatic opcode_e get_op(input logic [7:0] instr);
        return opcode_e'(instr[OP_MSB:OP_LSB]);
    endfunction

endpackage

// File: rtl/fetch_decode_exec_exec_alu.sv
// Combinational execute unit: ALU result, condition flag and the
// branch/restart "taken" decision for the current instruction.
module exec_alu
    import fde_pkg::*;
(
    input  opcode_e    i_op,
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [1:0] i_const,
    input  logic [7:0] i_start_addr,
    output logic [7:0] o_result,
    output logic       o_overflow,
    output logic       o_taken
);

    logic [8:0] w_add;
    logic [8:0] w_addi;

    assign w_add  = {1'b0, i_a} + {1'b0, i_b};
    assign w_addi = {1'b0, i_a} + {7'b0, i_const};

    always_comb begin
        o_result   = 8'h00;
        o_overflow = 1'b0;
        o_taken    = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result   = w_add[7:0];
                o_overflow = w_add[8];
            end
            OP_SUB: begin
                o_result   = i_a - i_b;
                o_overflow = (i_a < i_b);
            end
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_SHL:  o_result = i_a << i_const;
            OP_SHR:  o_result = i_a >> i_const;
            OP_ADDI: begin
                o_result   = w_addi[7:0];
                o_overflow = w_addi[8];
            end
            // Memory ops forward the address (port B) as the result.
            OP_LD:   o_result = i_b;
            OP_ST:   o_result = i_b;
            OP_CMP:  o_overflow = (i_a == i_b);
            OP_JMP: begin
                o_result = i_a;
                o_taken  = 1'b1;
            end
            OP_BZ: begin
                o_result = i_a;
                o_taken  = (i_b == 8'h00);
            end
            OP_RST: begin
                o_result = i_start_addr;
                o_taken  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_decode_exec.sv
// Single-cycle front end: PC register, instruction decode and execute.
// One instruction completes per clock; no pipeline or delay slot.
module fetch_decode_exec
    import fde_pkg::*;
#(
    parameter int DW = fde_pkg::DW
)
(
    input  logic          f_clk,
    input  logic          start,
    input  logic [DW-1:0] start_addr,
    input  logic [DW-1:0] instr_i,
    input  logic [DW-1:0] reg_a_i,
    input  logic [DW-1:0] reg_b_i,
    output logic [DW-1:0] pc_o,
    output logic [2:0]    rd_o,
    output logic [2:0]    rs1_o,
    output logic [2:0]    rs2_o,
    output logic [3:0]    label_rs_o,
    output logic          reg_write_o,
    output logic          mem_read_o,
    output logic          mem_write_o,
    output logic          label_read_o,
    output logic          label_write_o,
    output logic          branch_o,
    output logic          halt_o,
    output logic [DW-1:0] alu_out_o,
    output logic          overflow_o
);

    logic [DW-1:0] r_pc;
    opcode_e       w_op;
    logic          w_taken;

    assign w_op = get_op(instr_i);
    assign pc_o = r_pc;

    always_comb begin
        rd_o          = {1'b0, instr_i[RD_MSB:RD_LSB]};
        rs1_o         = {1'b0, instr_i[RD_MSB:RD_LSB]};
        rs2_o         = {1'b0, instr_i[RS2_MSB:RS2_LSB]};
        label_rs_o    = instr_i[LBL_MSB:LBL_LSB];
        reg_write_o   = 1'b0;
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        label_read_o  = 1'b0;
        label_write_o = 1'b0;
        branch_o      = 1'b0;
        halt_o        = 1'b0;
        case (w_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SHL, OP_SHR, OP_ADDI: reg_write_o = 1'b1;
            OP_LD: begin
                mem_read_o  = 1'b1;
                reg_write_o = 1'b1;
            end
            OP_ST:  mem_write_o   = 1'b1;
            OP_LBL: label_write_o = 1'b1;
            OP_JMP: begin
                label_read_o = 1'b1;
                branch_o     = 1'b1;
            end
            // BZ reads the tested value on port B from r0's slot.
            OP_BZ: begin
                label_read_o = 1'b1;
                branch_o     = 1'b1;
                rs2_o        = 3'd0;
            end
            OP_SYS: halt_o = (instr_i == HALT_WORD);
            default: ;
        endcase
    end

    exec_alu u_exec_alu (
        .i_op         (w_op),
        .i_a          (reg_a_i),
        .i_b          (reg_b_i),
        .i_const      (instr_i[RS2_MSB:RS2_LSB]),
        .i_start_addr (start_addr),
        .o_result     (alu_out_o),
        .o_overflow   (overflow_o),
        .o_taken      (w_taken)
    );

    // start wins over halt so a halted core can be restarted.
    always_ff @(posedge f_clk) begin
        if (start) begin
            r_pc <= start_addr;
        end else if (halt_o) begin
            r_pc <= r_pc;
        end else if (w_taken) begin
            r_pc <= alu_out_o;
        end else begin
            r_pc <= r_pc + {{(DW-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_fetch_decode_exec.sv
// Bench for fetch_decode_exec: directed literal checks followed by random
// instruction streams, all compared against an arithmetic reference model.
module tb_fetch_decode_exec;

    logic       f_clk;
    logic       start;
    logic [7:0] start_addr;
    logic [7:0] instr_i;
    logic [7:0] reg_a_i;
    logic [7:0] reg_b_i;
    logic [7:0] pc_o;
    logic [2:0] rd_o, rs1_o, rs2_o;
    logic [3:0] label_rs_o;
    logic       reg_write_o, mem_read_o, mem_write_o;
    logic       label_read_o, label_write_o, branch_o, halt_o;
    logic [7:0] alu_out_o;
    logic       overflow_o;

    int total = 0;
    int bad   = 0;
    bit run   = 0;

    logic [7:0] exp_pc;
    bit         pc_valid = 0;

    typedef struct {
        logic [7:0] alu;
        logic       ov;
        logic       taken;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [3:0] lbl;
        logic       rw, mr, mw, lr, lw, br, hl;
    } exp_t;

    fetch_decode_exec dut (
        .f_clk         (f_clk),
        .start         (start),
        .start_addr    (start_addr),
        .instr_i       (instr_i),
        .reg_a_i       (reg_a_i),
        .reg_b_i       (reg_b_i),
        .pc_o          (pc_o),
        .rd_o          (rd_o),
        .rs1_o         (rs1_o),
        .rs2_o         (rs2_o),
        .label_rs_o    (label_rs_o),
        .reg_write_o   (reg_write_o),
        .mem_read_o    (mem_read_o),
        .mem_write_o   (mem_write_o),
        .label_read_o  (label_read_o),
        .label_write_o (label_write_o),
        .branch_o      (branch_o),
        .halt_o        (halt_o),
        .alu_out_o     (alu_out_o),
        .overflow_o    (overflow_o)
    );

    initial f_clk = 1'b0;
    always #5 f_clk = ~f_clk;

    // Reference model: each opcode's meaning in plain integer arithmetic.
    function automatic exp_t model(input logic [7:0] ins, input logic [7:0] a,
                                   input logic [7:0] b, input logic [7:0] sa);
        exp_t e;
        int ia;
        int ib;
        int c;
        ia = int'(a);
        ib = int'(b);
        c  = int'(ins[1:0]);
        e.alu = 8'h00; e.ov = 1'b0; e.taken = 1'b0;
        e.rd  = {1'b0, ins[3:2]};
        e.rs1 = {1'b0, ins[3:2]};
        e.rs2 = {1'b0, ins[1:0]};
        e.lbl = ins[3:0];
        e.rw = 0; e.mr = 0; e.mw = 0; e.lr = 0; e.lw = 0; e.br = 0; e.hl = 0;
        case (int'(ins[7:4]))
            0: begin e.alu = 8'((ia + ib) % 256); e.ov = (ia + ib) > 255; e.rw = 1; end
            1: begin e.alu = 8'((ia - ib + 256) % 256); e.ov = ia < ib; e.rw = 1; end
            2: begin e.alu = a & b; e.rw = 1; end
            3: begin e.alu = a | b; e.rw = 1; end
            4: begin e.alu = a ^ b; e.rw = 1; end
            5: begin e.alu = 8'((ia * (1 << c)) % 256); e.rw = 1; end
            6: begin e.alu = 8'(ia / (1 << c)); e.rw = 1; end
            7: begin e.alu = 8'((ia + c) % 256); e.ov = (ia + c) > 255; e.rw = 1; end
            8: begin e.alu = b; e.mr = 1; e.rw = 1; end
            9: begin e.alu = b; e.mw = 1; end
            10: e.ov = (ia == ib);
            11: e.lw = 1;
            12: begin e.alu = a; e.lr = 1; e.br = 1; e.taken = 1; end
            13: begin e.alu = a; e.lr = 1; e.br = 1; e.rs2 = 3'd0; e.taken = (ib == 0); end
            14: begin e.alu = sa; e.taken = 1; end
            default: e.hl = (ins == 8'hFF);
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge f_clk) begin
        exp_t e;
        e = model(instr_i, reg_a_i, reg_b_i, start_addr);
        if (start) begin
            exp_pc   = start_addr;
            pc_valid = 1;
        end else if (pc_valid) begin
            if (e.hl) exp_pc = exp_pc;
            else if (e.taken) exp_pc = e.alu;
            else exp_pc = 8'((int'(exp_pc) + 1) % 256);
        end
    end

    always @(negedge f_clk) begin
        exp_t e;
        if (run) begin
            e = model(instr_i, reg_a_i, reg_b_i, start_addr);
            chk("alu_out", alu_out_o, e.alu);
            chk("overflow", {7'b0, overflow_o}, {7'b0, e.ov});
            chk("rd", {5'b0, rd_o}, {5'b0, e.rd});
            chk("rs1", {5'b0, rs1_o}, {5'b0, e.rs1});
            chk("rs2", {5'b0, rs2_o}, {5'b0, e.rs2});
            chk("label_rs", {4'b0, label_rs_o}, {4'b0, e.lbl});
            chk("ctrl", {1'b0, reg_write_o, mem_read_o, mem_write_o, label_read_o,
                         label_write_o, branch_o, halt_o},
                        {1'b0, e.rw, e.mr, e.mw, e.lr, e.lw, e.br, e.hl});
            if (pc_valid) chk("pc", pc_o, exp_pc);
        end
    end

    task automatic step(input logic st, input logic [7:0] sa, input logic [7:0] ins,
                        input logic [7:0] a, input logic [7:0] b);
        @(posedge f_clk);
        #1;
        start      = st;
        start_addr = sa;
        instr_i    = ins;
        reg_a_i    = a;
        reg_b_i    = b;
    endtask

    task automatic at_neg();
        @(negedge f_clk);
        #1;
    endtask

    initial begin
        start = 0; start_addr = 0; instr_i = 8'hF0; reg_a_i = 0; reg_b_i = 0;

        // Restart and sequential fetch
        step(1, 8'h10, 8'hF0, 0, 0);
        run = 1;
        step(0, 8'h10, 8'hF0, 0, 0); at_neg(); chk("lit_pc10", pc_o, 8'h10);
        step(0, 8'h10, 8'hF0, 0, 0); at_neg(); chk("lit_pc11", pc_o, 8'h11);
        step(0, 8'h10, 8'hF0, 0, 0); at_neg(); chk("lit_pc12", pc_o, 8'h12);
        step(1, 8'hFF, 8'hF0, 0, 0);
        step(0, 8'hFF, 8'hF0, 0, 0); at_neg(); chk("lit_pcFF", pc_o, 8'hFF);
        step(0, 8'hFF, 8'hF0, 0, 0); at_neg(); chk("lit_wrap", pc_o, 8'h00);

        // ALU ops
        step(0, 8'h10, 8'h01, 8'hF0, 8'h20); at_neg();
        chk("lit_add_alu", alu_out_o, 8'h10);
        chk("lit_add_ov", {7'b0, overflow_o}, 8'h01);
        chk("lit_add_rw", {7'b0, reg_write_o}, 8'h01);
        chk("lit_add_rd", {5'b0, rd_o}, 8'h00);
        chk("lit_add_rs2", {5'b0, rs2_o}, 8'h01);
        step(0, 8'h10, 8'h1E, 8'h05, 8'h07); at_neg();
        chk("lit_sub_alu", alu_out_o, 8'hFE);
        chk("lit_sub_ov", {7'b0, overflow_o}, 8'h01);
        step(0, 8'h10, 8'h1E, 8'h07, 8'h05); at_neg();
        chk("lit_sub2_alu", alu_out_o, 8'h02);
        chk("lit_sub2_ov", {7'b0, overflow_o}, 8'h00);

        // JMP then BZ not-taken and taken
        step(0, 8'h10, 8'hC3, 8'h40, 8'h00); at_neg();
        chk("lit_jmp_lr", {7'b0, label_read_o}, 8'h01);
        chk("lit_jmp_lbl", {4'b0, label_rs_o}, 8'h03);
        chk("lit_jmp_br", {7'b0, branch_o}, 8'h01);
        step(0, 8'h10, 8'hD3, 8'h50, 8'h01); at_neg(); chk("lit_jmp_pc", pc_o, 8'h40);
        step(0, 8'h10, 8'hD3, 8'h50, 8'h00); at_neg(); chk("lit_bz_nt_pc", pc_o, 8'h41);
        step(0, 8'h10, 8'hF0, 8'h00, 8'h00); at_neg(); chk("lit_bz_t_pc", pc_o, 8'h50);

        // RST jumps to start_addr
        step(0, 8'h77, 8'hE0, 8'h00, 8'h00);
        step(0, 8'h77, 8'hF0, 8'h00, 8'h00); at_neg(); chk("lit_rst_pc", pc_o, 8'h77);

        // HALT holds, start restarts
        step(1, 8'h22, 8'hFF, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 8'h22, 8'hFF, 0, 0); at_neg();
            chk("lit_halt_pc", pc_o, 8'h22);
            chk("lit_halt", {7'b0, halt_o}, 8'h01);
        end
        step(1, 8'h30, 8'hFF, 0, 0);
        step(0, 8'h30, 8'hFF, 0, 0); at_neg(); chk("lit_restart_pc", pc_o, 8'h30);

        // Memory ops
        step(0, 8'h30, 8'h97, 8'hAA, 8'h33); at_neg();
        chk("lit_st_mw", {7'b0, mem_write_o}, 8'h01);
        chk("lit_st_rw", {7'b0, reg_write_o}, 8'h00);
        chk("lit_st_alu", alu_out_o, 8'h33);
        step(0, 8'h30, 8'h8B, 8'hAA, 8'h33); at_neg();
        chk("lit_ld_mr", {7'b0, mem_read_o}, 8'h01);
        chk("lit_ld_rw", {7'b0, reg_write_o}, 8'h01);
        chk("lit_ld_rd", {5'b0, rd_o}, 8'h02);

        // Random streams, occasional restart; avoid long halts
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] ins;
            logic [7:0] b;
            ins = 8'($urandom_range(0, 255));
            if (ins == 8'hFF && $urandom_range(0, 3) != 0) ins = 8'hF0;
            b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            step(($urandom_range(0, 19) == 0), 8'($urandom_range(0, 255)), ins,
                 8'($urandom_range(0, 255)), b);
        end
        at_neg();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
